// File: rtl/snake_body_queue.sv
// Ring-buffer store of the snake's body coordinates with a serial self-collision
// scanner, an init loader and an indexed registered read port (index 0 = head).
module snake_body_queue #(
  parameter int MAX_LEN  = 256,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 30,
  parameter int INIT_Y   = 40
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Init,
  input  logic       i_Start,
  input  logic [6:0] i_Head_x,
  input  logic [6:0] i_Head_y,
  input  logic       i_Grow,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Hit,
  output logic [8:0] o_Len,
  input  logic [8:0] i_Rd_idx,
  output logic [6:0] o_Rd_x,
  output logic [6:0] o_Rd_y
);

  localparam int PW = $clog2(MAX_LEN);
  localparam logic [6:0] INIT_XV   = 7'(INIT_X);
  localparam logic [6:0] INIT_YTOP = 7'(INIT_Y + INIT_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SCAN, S_UPDATE, S_DONE} state_t;

  state_t        state;
  logic [13:0]   mem [MAX_LEN];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] tail_ptr;
  logic [8:0]    scan_n;
  logic [8:0]    scan_idx;
  logic [8:0]    init_k;
  logic [6:0]    head_x;
  logic [6:0]    head_y;
  logic          grow;
  logic          hit;

  logic [8:0]    n_next;
  logic [PW-1:0] scan_addr;
  logic [PW-1:0] rd_addr;
  logic          scan_hit;
  logic          mem_we;
  logic [13:0]   mem_wd;

  assign o_Busy    = (state != S_IDLE);
  // Segment i sits i slots behind the newest write.
  assign scan_addr = wr_ptr - PW'(1) - scan_idx[PW-1:0];
  assign rd_addr   = wr_ptr - PW'(1) - i_Rd_idx[PW-1:0];
  assign scan_hit  = (mem[scan_addr] == {head_x, head_y});
  assign n_next    = i_Grow ? o_Len : ((o_Len == 9'd0) ? 9'd0 : o_Len - 9'd1);

  always_comb begin
    mem_we = 1'b0;
    mem_wd = '0;
    if (state == S_INIT) begin
      mem_we = 1'b1;
      mem_wd = {INIT_XV, INIT_YTOP - init_k[6:0]};
    end else if (state == S_UPDATE && !hit) begin
      mem_we = 1'b1;
      mem_wd = {head_x, head_y};
    end
  end

  // NOTE: the body store has no reset; o_Len gates every read, so stale
  // contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge i_Clk) begin
    if (mem_we) mem[wr_ptr] <= mem_wd;
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      o_Rd_x <= '0;
      o_Rd_y <= '0;
    end else if (i_Rd_idx < o_Len) begin
      o_Rd_x <= mem[rd_addr][13:7];
      o_Rd_y <= mem[rd_addr][6:0];
    end else begin
      o_Rd_x <= '0;
      o_Rd_y <= '0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      tail_ptr <= '0;
      o_Len    <= '0;
      o_Done   <= 1'b0;
      o_Hit    <= 1'b0;
      scan_n   <= '0;
      scan_idx <= '0;
      init_k   <= '0;
      head_x   <= '0;
      head_y   <= '0;
      grow     <= 1'b0;
      hit      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_Init) begin
            wr_ptr   <= '0;
            tail_ptr <= '0;
            o_Len    <= '0;
            init_k   <= '0;
            state    <= S_INIT;
          end else if (i_Start) begin
            head_x   <= i_Head_x;
            head_y   <= i_Head_y;
            grow     <= i_Grow;
            hit      <= 1'b0;
            scan_idx <= '0;
            scan_n   <= n_next;
            state    <= (n_next != 9'd0) ? S_SCAN : S_UPDATE;
          end
        end
        S_INIT: begin
          wr_ptr <= wr_ptr + PW'(1);
          init_k <= init_k + 9'd1;
          if (init_k == 9'(INIT_LEN - 1)) begin
            o_Len <= 9'(INIT_LEN);
            state <= S_IDLE;
          end
        end
        S_SCAN: begin
          // Sticky: any match among the scanned segments ends the game.
          if (scan_hit) hit <= 1'b1;
          scan_idx <= scan_idx + 9'd1;
          if (scan_idx == scan_n - 9'd1) state <= S_UPDATE;
        end
        S_UPDATE: begin
          if (!hit) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (grow && o_Len < 9'(MAX_LEN)) o_Len <= o_Len + 9'd1;
            else tail_ptr <= tail_ptr + PW'(1);
          end
          o_Done <= 1'b1;
          o_Hit  <= hit;
          state  <= S_DONE;
        end
        S_DONE: begin
          o_Done <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_queue.sv
// Directed bench for snake_body_queue: a default-size instance and an
// 8-entry instance share stimulus; use_small selects which one is observed.
module tb_snake_body_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       init = 1'b0;
  logic       start = 1'b0;
  logic [6:0] hx = '0;
  logic [6:0] hy = '0;
  logic       grow = 1'b0;
  logic [8:0] rd_idx = '0;
  logic       use_small = 1'b0;

  logic       busy_b, done_b, hit_b, busy_s, done_s, hit_s;
  logic [8:0] len_b, len_s;
  logic [6:0] rdx_b, rdy_b, rdx_s, rdy_s;

  logic       busy, done, hit;
  logic [8:0] len;
  logic [6:0] rdx, rdy;

  int total = 0;
  int bad   = 0;

  snake_body_queue u_big (
    .i_Clk(clk), .i_Rst(rst), .i_Init(init), .i_Start(start),
    .i_Head_x(hx), .i_Head_y(hy), .i_Grow(grow),
    .o_Busy(busy_b), .o_Done(done_b), .o_Hit(hit_b), .o_Len(len_b),
    .i_Rd_idx(rd_idx), .o_Rd_x(rdx_b), .o_Rd_y(rdy_b)
  );

  snake_body_queue #(.MAX_LEN(8)) u_small (
    .i_Clk(clk), .i_Rst(rst), .i_Init(init), .i_Start(start),
    .i_Head_x(hx), .i_Head_y(hy), .i_Grow(grow),
    .o_Busy(busy_s), .o_Done(done_s), .o_Hit(hit_s), .o_Len(len_s),
    .i_Rd_idx(rd_idx), .o_Rd_x(rdx_s), .o_Rd_y(rdy_s)
  );

  assign busy = use_small ? busy_s : busy_b;
  assign done = use_small ? done_s : done_b;
  assign hit  = use_small ? hit_s  : hit_b;
  assign len  = use_small ? len_s  : len_b;
  assign rdx  = use_small ? rdx_s  : rdx_b;
  assign rdy  = use_small ? rdy_s  : rdy_b;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_len", len, 0);
    check("rst_done", done, 0);
    check("rst_hit", hit, 0);
    check("rst_rdx", rdx, 0);
    check("rst_rdy", rdy, 0);
    rst = 1'b1;
  endtask

  task automatic do_init();
    @(negedge clk);
    init = 1'b1;
    @(posedge clk);
    #1 init = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("init_busy", busy, 1);
    end
    @(negedge clk);
    check("init_idle", busy, 0);
    check("init_len", len, 3);
  endtask

  task automatic rd(input string tag, input logic [8:0] idx, input logic [6:0] ex, input logic [6:0] ey);
    @(negedge clk);
    rd_idx = idx;
    @(negedge clk);
    check({tag, "_x"}, rdx, ex);
    check({tag, "_y"}, rdy, ey);
  endtask

  // Issues one Start, optionally pokes a stray Start while busy, and checks
  // latency (negedges after the accepting edge until o_Done), hit and length.
  task automatic start_op(input string tag, input logic [6:0] x, input logic [6:0] y,
                          input logic g, input int exp_lat, input logic exp_hit,
                          input int exp_len, input bit poke);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    hx = x; hy = y; grow = g; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hx = 7'h7f; hy = 7'h7f; grow = ~g;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (poke && c == 1) begin
        start = 1'b1; hx = 7'd5; hy = 7'd5;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    start = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_hit"}, hit, exp_hit);
    check({tag, "_len"}, len, exp_len);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int done_cnt;

    // 1: reset and init on the default-size instance
    use_small = 1'b0;
    do_reset();
    do_init();
    rd("t1_i0", 9'd0, 7'd30, 7'd40);
    rd("t1_i2", 9'd2, 7'd30, 7'd42);
    rd("t1_i3", 9'd3, 7'd0, 7'd0);

    // 2: plain move
    start_op("t2", 7'd30, 7'd39, 1'b0, 4, 1'b0, 3, 1'b0);
    rd("t2_i0", 9'd0, 7'd30, 7'd39);
    rd("t2_i2", 9'd2, 7'd30, 7'd41);

    // 3: grow, with a stray Start while busy
    start_op("t3", 7'd29, 7'd39, 1'b1, 5, 1'b0, 4, 1'b1);
    rd("t3_i0", 9'd0, 7'd29, 7'd39);
    rd("t3_i3", 9'd3, 7'd30, 7'd41);
    check("t3_len_after", len, 4);

    // 4: build the square body, then tail chase vs grow into tail
    start_op("t4_b0", 7'd30, 7'd41, 1'b0, 5, 1'b0, 4, 1'b0);
    start_op("t4_b1", 7'd31, 7'd41, 1'b0, 5, 1'b0, 4, 1'b0);
    start_op("t4_b2", 7'd31, 7'd40, 1'b0, 5, 1'b0, 4, 1'b0);
    start_op("t4_b3", 7'd30, 7'd40, 1'b0, 5, 1'b0, 4, 1'b0);
    start_op("t4_chase", 7'd30, 7'd41, 1'b0, 5, 1'b0, 4, 1'b0);
    rd("t4_c0", 9'd0, 7'd30, 7'd41);
    start_op("t4_r0", 7'd31, 7'd41, 1'b0, 5, 1'b0, 4, 1'b0);
    start_op("t4_r1", 7'd31, 7'd40, 1'b0, 5, 1'b0, 4, 1'b0);
    start_op("t4_r2", 7'd30, 7'd40, 1'b0, 5, 1'b0, 4, 1'b0);
    start_op("t4_grow_hit", 7'd30, 7'd41, 1'b1, 6, 1'b1, 4, 1'b0);
    rd("t4_h0", 9'd0, 7'd30, 7'd40);
    rd("t4_h1", 9'd1, 7'd31, 7'd40);
    rd("t4_h2", 9'd2, 7'd31, 7'd41);
    rd("t4_h3", 9'd3, 7'd30, 7'd41);
    rd("t4_h4", 9'd4, 7'd0, 7'd0);

    // 5: 8-entry instance, grow to full and past the pointer wrap
    use_small = 1'b1;
    do_reset();
    do_init();
    start_op("t5_g1", 7'd1, 7'd1, 1'b1, 5, 1'b0, 4, 1'b0);
    start_op("t5_g2", 7'd1, 7'd2, 1'b1, 6, 1'b0, 5, 1'b0);
    start_op("t5_g3", 7'd1, 7'd3, 1'b1, 7, 1'b0, 6, 1'b0);
    start_op("t5_g4", 7'd1, 7'd4, 1'b1, 8, 1'b0, 7, 1'b0);
    start_op("t5_g5", 7'd1, 7'd5, 1'b1, 9, 1'b0, 8, 1'b0);
    start_op("t5_full", 7'd1, 7'd6, 1'b1, 10, 1'b0, 8, 1'b0);
    rd("t5_f0", 9'd0, 7'd1, 7'd6);
    rd("t5_f7", 9'd7, 7'd30, 7'd41);
    rd("t5_f8", 9'd8, 7'd0, 7'd0);
    start_op("t5_w1", 7'd1, 7'd7, 1'b1, 10, 1'b0, 8, 1'b0);
    start_op("t5_w2", 7'd1, 7'd8, 1'b1, 10, 1'b0, 8, 1'b0);
    rd("t5_w0", 9'd0, 7'd1, 7'd8);
    rd("t5_w2r", 9'd2, 7'd1, 7'd6);
    rd("t5_w7", 9'd7, 7'd1, 7'd1);
    rd("t5_w8", 9'd8, 7'd0, 7'd0);

    // 6: reset during SCAN aborts without a Done pulse
    use_small = 1'b0;
    do_reset();
    do_init();
    @(negedge clk);
    hx = 7'd5; hy = 7'd5; grow = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t6_busy_scan", busy, 1);
    rst = 1'b0;
    #1;
    check("t6_abort_busy", busy, 0);
    check("t6_abort_len", len, 0);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("t6_no_done", done_cnt, 0);
    rst = 1'b1;
    do_init();
    rd("t6_i0", 9'd0, 7'd30, 7'd40);
    rd("t6_i2", 9'd2, 7'd30, 7'd42);
    rd("t6_i3", 9'd3, 7'd0, 7'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_body_queue.md
Name: snake_body_queue

Overview:
- Ring-buffer store of the snake's body segment coordinates, with a serial self-collision scanner.
- Sits directly downstream of the game controller: in its SETQU state the controller hands over the new head position and a grow flag, then waits for o_Done.
- Also serves the VGA/output stage through an indexed read port during TRANSPORT.
- Coordinate (0,0) is NULL throughout.

Parameters:
- MAX_LEN, 256, ring capacity in segments; power of two; pointers are log2(MAX_LEN) bits.
- INIT_LEN, 3, segments written by an init command.
- INIT_X, 30, head x written by init.
- INIT_Y, 40, head y written by init.

Ports:
- i_Clk  input  1  clock; all state changes on rising edge.
- i_Rst  input  1  asynchronous active-low reset.
- i_Init  input  1  pulse: load initial body; accepted only in IDLE.
- i_Start  input  1  pulse: push new head; accepted only in IDLE.
- i_Head_x  input  7  new head x, latched on accepted i_Start.
- i_Head_y  input  7  new head y, latched on accepted i_Start.
- i_Grow  input  1  1 = keep tail (snake grows), latched with i_Start.
- o_Busy  output  1  high in every state except IDLE.
- o_Done  output  1  one-cycle pulse at end of a Start operation.
- o_Hit  output  1  self-collision result; updated in the o_Done cycle, held until the next o_Done or reset.
- o_Len  output  9  current segment count, 0..MAX_LEN.
- i_Rd_idx  input  9  read index; 0 = head (newest), o_Len-1 = tail.
- o_Rd_x  output  7  registered x of segment i_Rd_idx; 1-cycle latency.
- o_Rd_y  output  7  registered y of segment i_Rd_idx; 1-cycle latency.

Behaviour:
- Reset (asynchronous):
  - State IDLE; wr_ptr = tail_ptr = 0; o_Len = 0.
  - o_Done = 0, o_Hit = 0, o_Rd_x = o_Rd_y = 0.
  - Storage contents are don't-care; memory is not reset.
- Storage and pointers:
  - wr_ptr is the next free slot; tail_ptr is the oldest segment.
  - Segment i lives at (wr_ptr-1-i) mod MAX_LEN.
- States: IDLE, INIT, SCAN, UPDATE, DONE.
- IDLE:
  - i_Init has priority over i_Start if both are high.
  - i_Init -> INIT: clear pointers, counter k = 0.
  - i_Start -> latch head/grow; N = i_Grow ? o_Len : o_Len-1 (floor 0); index = 0.
  - Start goes to SCAN if N > 0, else UPDATE.
- INIT:
  - One write per cycle: (INIT_X, INIT_Y+INIT_LEN-1-k) for k = 0..INIT_LEN-1, so the tail is written first.
  - After the last write: o_Len = INIT_LEN, return to IDLE. Takes INIT_LEN cycles.
- SCAN:
  - One segment per cycle, index 0..N-1; set a sticky hit flag if the segment equals the latched head.
  - Tail excluded when not growing, since it vacates the same tick.
  - After index N-1 -> UPDATE.
- UPDATE:
  - If hit: no write; pointers and o_Len unchanged; the queue freezes for game over.
  - Else write head at wr_ptr, wr_ptr+1.
  - If grow and o_Len < MAX_LEN: o_Len+1.
  - Otherwise tail_ptr+1 and o_Len unchanged; grow at full capacity behaves as a plain move.
- DONE: o_Done = 1 for one cycle, o_Hit = flag, -> IDLE.
- Latency: Start accepted on edge t -> o_Done high in cycle t+N+2. New contents are readable from the o_Done cycle.
- Ignored inputs:
  - i_Start or i_Init while o_Busy = 1.
  - i_Head and i_Grow changes after latch.
- Read port:
  - Index >= o_Len returns (0,0).
  - Reads are always valid, including while busy; they show pre-update contents until UPDATE commits.
- Reset mid-operation: abort immediately, no o_Done pulse, o_Len = 0; a fresh Init is required.
- Pointer arithmetic wraps modulo MAX_LEN; o_Len never exceeds MAX_LEN and never underflows.

Test Plan:
1. Reset, i_Init -> o_Busy for 3 cycles then IDLE; o_Len=3; reads idx0=(30,40), idx2=(30,42), idx3=(0,0).
2. After init, Start head (30,39) grow=0 at edge t -> o_Done at t+4, o_Hit=0, o_Len=3; idx0=(30,39), idx2=(30,41).
3. After 2, Start (29,39) grow=1 -> o_Done at t+5, o_Len=4; idx3=(30,41); a simultaneous Start during busy is ignored.
4. Build body (30,40)(31,40)(31,41)(30,41), then Start (30,41) grow=0 -> o_Hit=0 (tail chase). The same with grow=1 -> o_Hit=1, o_Len unchanged, contents unchanged.
5. MAX_LEN=8 variant: grow until o_Len=8, grow once more -> o_Len stays 8, oldest segment dropped; repeat past pointer wrap and check ordering via reads.
6. Assert i_Rst low during SCAN -> o_Busy=0, o_Len=0, no o_Done; i_Init then behaves as in test 1.
